mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word-address width of the shared memory.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, max consecutive denied cycles for port 1 in fixed-priority mode (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports p0_valid / p1_valid  input  1  requester N has a pending request.
REQ-006 SHALL have ports p0_ready / p1_ready  output  1  request of port N accepted this cycle.
REQ-007 SHALL have ports p0_write / p1_write  input  1  request is a write (0 = read).
REQ-008 SHALL have ports p0_wmask / p1_wmask  input  4  byte-enable for writes; bit i enables byte i.
REQ-009 SHALL have ports p0_wdata / p1_wdata  input  32  write data.
REQ-010 SHALL have ports p0_addr / p1_addr  input  ADDR_WIDTH  word address.
REQ-011 SHALL have ports p0_rvalid / p1_rvalid  output  1  read data for port N valid this cycle.
REQ-012 SHALL have ports p0_rdata / p1_rdata  output  32  read data; meaningful only with matching rvalid.
REQ-013 SHALL have ports mem_valid, mem_write  output  1 each  access strobe and write enable to the memory.
REQ-014 SHALL have ports mem_wmask  output  4; mem_wdata  output  32; mem_addr  output  ADDR_WIDTH.
REQ-015 SHALL have port mem_rdata  input  32  memory read data, one cycle after address.

Function
REQ-016 SHALL grant at most one port per cycle; pN_ready is combinational from valids and arbitration state.
REQ-017 SHALL treat valid & ready as a transfer; one transfer per cycle max, back-to-back allowed.
REQ-018 SHALL drive mem_valid = p0_valid | p1_valid, and mem_write/wmask/wdata/addr from the granted port in the same cycle.
REQ-019 SHALL, for a read transferred in cycle t, assert that port's rvalid in cycle t+1 with pN_rdata = mem_rdata; rvalid is a registered per-port flag.
REQ-020 SHALL NOT assert rvalid for writes; write with wmask 0 is a transfer changing no byte.
REQ-021 SHALL hold pN_ready low for a non-requesting port; a single requester is granted immediately (no idle cycles).
REQ-022 Requesters SHALL keep request fields stable while valid & ~ready; the arbiter does not check this.

Reset
REQ-023 SHALL, while rstn low, force p0_rvalid = p1_rvalid = 0, starvation counter = 0, RR pointer = port 0.
REQ-024 SHALL drop any read outstanding at reset assertion; no rvalid after rstn deasserts.
REQ-025 Combinational outputs SHALL follow REQ-016/018 during reset; requesters must hold valid low until reset ends.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined: on conflict, grant the port not granted in the last conflict-free-or-conflict transfer (1-bit pointer, toggles to the other port after each grant); STARVE_LIMIT unused.
REQ-027 Without ARB_ROUND_ROBIN_EN: port 0 wins conflicts; counter increments each cycle p1 is valid and denied, clears on p1 grant; when counter == STARVE_LIMIT, p1 wins next conflict.

Verification
REQ-028 Reset, p0 read addr 0x10 (mem word 0xDEADBEEF) -> p0_ready=1 in t, p0_rvalid=1, p0_rdata=0xDEADBEEF in t+1, p1_rvalid=0.
REQ-029 p1 write addr 0x20, wmask 4'b0011, wdata 0x12345678 over 0xAAAAAAAA, then p1 read 0x20 -> rvalid only after read, rdata 0xAAAA5678.
REQ-030 Fixed mode, both valid reads for 6 cycles, STARVE_LIMIT 3 -> grants p0,p0,p0,p1,p0,p0; each rvalid routed to correct port.
REQ-031 ARB_ROUND_ROBIN_EN, both valid reads for 4 cycles after reset -> grants p0,p1,p0,p1; mem_valid=1 every cycle.
REQ-032 p0 read transferred, rstn pulsed low next cycle -> p0_rvalid stays 0, counter/pointer back to reset values.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  p0_valid;
  logic                  p0_ready;
  logic                  p0_write;
  logic [3:0]            p0_wmask;
  logic [31:0]           p0_wdata;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic                  p0_rvalid;
  logic [31:0]           p0_rdata;

  logic                  p1_valid;
  logic                  p1_ready;
  logic                  p1_write;
  logic [3:0]            p1_wmask;
  logic [31:0]           p1_wdata;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic                  p1_rvalid;
  logic [31:0]           p1_rdata;

  logic                  mem_valid;
  logic                  mem_write;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_rdata;

  modport slave (
    input  p0_valid, p0_write, p0_wmask, p0_wdata, p0_addr,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_valid, p1_write, p1_wmask, p1_wdata, p1_addr,
    output p1_ready, p1_rvalid, p1_rdata,
    output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    input  mem_rdata
  );

  modport master (
    output p0_valid, p0_write, p0_wmask, p0_wdata, p0_addr,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_valid, p1_write, p1_wmask, p1_wdata, p1_addr,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single-ported memory with one-cycle read latency.
// Define ARB_ROUND_ROBIN_EN for round-robin conflicts; default is port 0 priority with p1 starvation guard.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 3
) (
  input logic            clk,
  input logic            rstn,
  mem_arbiter_if.slave   bus
);

  logic p1_wins;
  logic grant0;
  logic grant1;
  logic rvalid0;
  logic rvalid1;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_ptr = 1 means port 1 has priority on the next conflict
  logic rr_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= 1'b0;
    end else if (grant0) begin
      rr_ptr <= 1'b1;
    end else if (grant1) begin
      rr_ptr <= 1'b0;
    end
  end

  assign p1_wins = rr_ptr;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= 4'd0;
    end else if (grant1) begin
      starve_cnt <= 4'd0;
    end else if (bus.p1_valid && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign p1_wins = (starve_cnt == LIMIT);
`endif

  assign grant0 = bus.p0_valid & ~(bus.p1_valid & p1_wins);
  assign grant1 = bus.p1_valid & (~bus.p0_valid | p1_wins);

  assign bus.p0_ready  = grant0;
  assign bus.p1_ready  = grant1;
  assign bus.mem_valid = bus.p0_valid | bus.p1_valid;

  always_comb begin
    bus.mem_write = 1'b0;
    bus.mem_wmask = 4'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_addr  = '0;
    if (grant1) begin
      bus.mem_write = bus.p1_write;
      bus.mem_wmask = bus.p1_wmask;
      bus.mem_wdata = bus.p1_wdata;
      bus.mem_addr  = bus.p1_addr;
    end else if (grant0) begin
      bus.mem_write = bus.p0_write;
      bus.mem_wmask = bus.p0_wmask;
      bus.mem_wdata = bus.p0_wdata;
      bus.mem_addr  = bus.p0_addr;
    end
  end

  // Reset clears these flags, so a read in flight at reset never returns
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= grant0 & ~bus.p0_write;
      rvalid1 <= grant1 & ~bus.p1_write;
    end
  end

  assign bus.p0_rvalid = rvalid0;
  assign bus.p1_rvalid = rvalid1;
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, cycle scoreboard and directed vectors.
module tb_mem_arbiter;
  localparam int AW = 14;
  localparam int SL = 3;

  logic clk;
  logic rstn;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment memory attached to the shared port
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (bus.mem_valid) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) env_mem[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end else begin
        bus.mem_rdata <= env_mem[bus.mem_addr[7:0]];
      end
    end
  end

  // Behavioural model state
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  int          m_denied;    // consecutive cycles p1 asked and lost
  int          m_last;      // last granted port

  initial begin : scoreboard
    logic        e_g0, e_g1, p1_pref;
    logic        n_rv0, n_rv1;
    logic [31:0] n_rd0, n_rd1;
    logic        e_w;
    logic [3:0]  e_m;
    logic [31:0] e_d;
    logic [7:0]  e_a;
    m_rv0 = 0; m_rv1 = 0; m_rd0 = 0; m_rd1 = 0; m_denied = 0; m_last = 1;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_rv0 = 0; m_rv1 = 0; m_denied = 0; m_last = 1;
      end
`ifdef ARB_ROUND_ROBIN_EN
      p1_pref = (m_last == 0);
`else
      p1_pref = (m_denied >= SL);
`endif
      if (bus.p0_valid && bus.p1_valid) begin
        e_g1 = p1_pref;
        e_g0 = !p1_pref;
      end else begin
        e_g0 = bus.p0_valid;
        e_g1 = bus.p1_valid;
      end
      check("sb_p0_ready", bus.p0_ready, e_g0);
      check("sb_p1_ready", bus.p1_ready, e_g1);
      check("sb_mem_valid", bus.mem_valid, bus.p0_valid | bus.p1_valid);
      check("sb_p0_rvalid", bus.p0_rvalid, m_rv0);
      check("sb_p1_rvalid", bus.p1_rvalid, m_rv1);
      if (m_rv0) check("sb_p0_rdata", bus.p0_rdata, m_rd0);
      if (m_rv1) check("sb_p1_rdata", bus.p1_rdata, m_rd1);

      n_rv0 = 0; n_rv1 = 0; n_rd0 = m_rd0; n_rd1 = m_rd1;
      if (e_g0 || e_g1) begin
        e_w = e_g1 ? bus.p1_write : bus.p0_write;
        e_m = e_g1 ? bus.p1_wmask : bus.p0_wmask;
        e_d = e_g1 ? bus.p1_wdata : bus.p0_wdata;
        e_a = e_g1 ? bus.p1_addr[7:0] : bus.p0_addr[7:0];
        check("sb_mem_write", bus.mem_write, e_w);
        check("sb_mem_addr", bus.mem_addr[7:0], e_a);
        if (e_w) begin
          check("sb_mem_wmask", bus.mem_wmask, e_m);
          check("sb_mem_wdata", bus.mem_wdata, e_d);
          for (int b = 0; b < 4; b++)
            if (e_m[b]) ref_mem[e_a][b*8 +: 8] = e_d[b*8 +: 8];
        end else if (e_g0) begin
          n_rv0 = 1; n_rd0 = ref_mem[e_a];
        end else begin
          n_rv1 = 1; n_rd1 = ref_mem[e_a];
        end
      end

      @(posedge clk);
      if (rstn) begin
        m_rv0 = n_rv0; m_rv1 = n_rv1; m_rd0 = n_rd0; m_rd1 = n_rd1;
        if (e_g1) m_denied = 0;
        else if (bus.p1_valid) m_denied++;
        if (e_g0) m_last = 0;
        else if (e_g1) m_last = 1;
      end
    end
  end

  task automatic req0(input logic v, input logic w, input logic [3:0] m, input logic [31:0] d, input logic [7:0] a);
    bus.p0_valid = v; bus.p0_write = w; bus.p0_wmask = m; bus.p0_wdata = d; bus.p0_addr = AW'(a);
  endtask

  task automatic req1(input logic v, input logic w, input logic [3:0] m, input logic [31:0] d, input logic [7:0] a);
    bus.p1_valid = v; bus.p1_write = w; bus.p1_wmask = m; bus.p1_wdata = d; bus.p1_addr = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v0; logic w0; logic [3:0] m0; logic [31:0] d0; logic [7:0] a0;
    logic v1; logic w1; logic [3:0] m1; logic [31:0] d1; logic [7:0] a1;
  } vec_t;

  vec_t        vecs [9];
  logic [1:0]  grants [6];
  logic [1:0]  exp_c [6];

  initial begin : stimulus
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    env_mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    env_mem[8'h20] = 32'hAAAAAAAA; ref_mem[8'h20] = 32'hAAAAAAAA;

    vecs[0] = '{1, 1, 4'hF, 32'h11223344, 8'h50, 1, 1, 4'hC, 32'h55667788, 8'h51};
    vecs[1] = '{1, 0, 4'h0, 32'h0,        8'h51, 1, 1, 4'h0, 32'hFFFFFFFF, 8'h50};
    vecs[2] = '{1, 0, 4'h0, 32'h0,        8'h50, 1, 0, 4'h0, 32'h0,        8'h50};
    vecs[3] = '{0, 0, 4'h0, 32'h0,        8'h00, 1, 1, 4'h5, 32'hA5A5A5A5, 8'h52};
    vecs[4] = '{1, 0, 4'h0, 32'h0,        8'h52, 1, 0, 4'h0, 32'h0,        8'h51};
    vecs[5] = '{1, 1, 4'h8, 32'h77000000, 8'h52, 0, 0, 4'h0, 32'h0,        8'h00};
    vecs[6] = '{1, 0, 4'h0, 32'h0,        8'h10, 1, 0, 4'h0, 32'h0,        8'h52};
    vecs[7] = '{0, 0, 4'h0, 32'h0,        8'h00, 0, 0, 4'h0, 32'h0,        8'h00};
    vecs[8] = '{0, 0, 4'h0, 32'h0,        8'h00, 0, 0, 4'h0, 32'h0,        8'h00};

`ifdef ARB_ROUND_ROBIN_EN
    exp_c = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_c = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
`endif

    rstn = 1'b0;
    req0(0, 0, 0, 0, 0);
    req1(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // p0 read of a known word
    req0(1, 0, 4'h0, 32'h0, 8'h10);
    @(negedge clk);
    check("A_p0_ready", bus.p0_ready, 1'b1);
    tick();
    req0(0, 0, 0, 0, 0);
    @(negedge clk);
    check("A_p0_rvalid", bus.p0_rvalid, 1'b1);
    check("A_p0_rdata", bus.p0_rdata, 32'hDEADBEEF);
    check("A_p1_rvalid", bus.p1_rvalid, 1'b0);

    // p1 partial write then read-back
    tick();
    req1(1, 1, 4'b0011, 32'h12345678, 8'h20);
    @(negedge clk);
    check("B_p1_wready", bus.p1_ready, 1'b1);
    tick();
    req1(1, 0, 4'h0, 32'h0, 8'h20);
    @(negedge clk);
    check("B_no_rvalid_on_write", bus.p1_rvalid, 1'b0);
    tick();
    req1(0, 0, 0, 0, 0);
    @(negedge clk);
    check("B_p1_rvalid", bus.p1_rvalid, 1'b1);
    check("B_p1_rdata", bus.p1_rdata, 32'hAAAA5678);

    // Sustained conflict straight out of reset
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    req0(1, 0, 4'h0, 32'h0, 8'h30);
    req1(1, 0, 4'h0, 32'h0, 8'h40);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      grants[i] = {bus.p1_ready, bus.p0_ready};
      check("C_mem_valid", bus.mem_valid, 1'b1);
      tick();
    end
    req0(0, 0, 0, 0, 0);
    req1(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      check($sformatf("C_grant%0d", i), grants[i], exp_c[i]);

    // Build arbitration history, leave a read in flight, then reset
    tick();
    req0(1, 0, 4'h0, 32'h0, 8'h31);
    req1(1, 0, 4'h0, 32'h0, 8'h41);
    repeat (3) tick();
    req1(0, 0, 0, 0, 0);
    @(negedge clk);
    check("D_p0_ready", bus.p0_ready, 1'b1);
    tick();
    req0(0, 0, 0, 0, 0);
    rstn = 1'b0;
    @(negedge clk);
    check("D_rvalid_in_reset", bus.p0_rvalid, 1'b0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("D_rvalid_after_reset", bus.p0_rvalid, 1'b0);
    tick();
    req0(1, 0, 4'h0, 32'h0, 8'h32);
    req1(1, 0, 4'h0, 32'h0, 8'h42);
    @(negedge clk);
    check("D_first_grant", {bus.p1_ready, bus.p0_ready}, 2'b01);
    tick();

    // Mixed traffic checked by the scoreboard
    foreach (vecs[i]) begin
      req0(vecs[i].v0, vecs[i].w0, vecs[i].m0, vecs[i].d0, vecs[i].a0);
      req1(vecs[i].v1, vecs[i].w1, vecs[i].m1, vecs[i].d1, vecs[i].a1);
      tick();
    end
    req0(0, 0, 0, 0, 0);
    req1(0, 0, 0, 0, 0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
